// File: rtl/frame_painter.sv
// frame_painter: raster-scans a frame and paints ball, plate and 7-segment digits into a pixel sink.
// Define FRAME_PAINTER_BORDER_EN to also paint a separator column at SEP_X.
module frame_painter #(
   parameter  int SCR_W       = 160,
   parameter  int SCR_H       = 120,
   parameter  int NUM_DIGITS  = 9,
   parameter  int DIG_PER_ROW = 4,
   parameter  int DIG_X0      = 125,
   parameter  int DIG_Y0      = 8,
   parameter  int DIG_PITCH   = 7,
   parameter  int ROW_PITCH   = 24,
   parameter  int PLATE_H     = 4,
   parameter  int SEP_X       = 121,
   localparam int XW          = $clog2(SCR_W),
   localparam int YW          = $clog2(SCR_H)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [XW-1:0]           ballx,
   input  logic [YW-1:0]           bally,
   input  logic [XW-1:0]           platex,
   input  logic [YW-1:0]           platey,
   input  logic [5:0]              ballsize,
   input  logic [5:0]              platesize,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic                    redraw,
   input  logic                    wr_ready,
   output logic [XW-1:0]           x,
   output logic [YW-1:0]           y,
   output logic [2:0]              color,
   output logic                    plot,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int XE = XW + 1;
   localparam int YE = YW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PAINT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [XW-1:0]           x_q, x_d;
   logic [YW-1:0]           y_q, y_d;
   logic                    pending_q, pending_d;
   logic [XW-1:0]           bx_q, bx_d, px_q, px_d;
   logic [YW-1:0]           by_q, by_d, py_q, py_d;
   logic [5:0]              bs_q, bs_d, ps_q, ps_d;
   logic [4*NUM_DIGITS-1:0] dig_q, dig_d;

   logic                    start_c;
   logic                    enter_paint;
   logic                    accept;
   logic                    last_px;
   logic [XE-1:0]           xe;
   logic [YE-1:0]           ye;
   int                      xi, yi;
   logic                    ball_hit, plate_hit, seg_hit;
   logic [NUM_DIGITS-1:0]   dig_hit;
   logic [2:0]              pix_c;

   // Segment order gfedcba; codes above 9 are blank.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Any object input that differs from the painted snapshot, or an explicit request, starts a frame.
   assign start_c = redraw
                  | (ballx != bx_q) | (bally != by_q)
                  | (platex != px_q) | (platey != py_q)
                  | (ballsize != bs_q) | (platesize != ps_q)
                  | (digits != dig_q);

   assign accept      = (state_q == S_PAINT) && wr_ready;
   assign last_px     = (x_q == XW'(SCR_W - 1)) && (y_q == YW'(SCR_H - 1));
   assign enter_paint = (state_d == S_PAINT) && (state_q != S_PAINT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_c || pending_q) state_d = S_PAINT;
         S_PAINT: if (accept && last_px) state_d = S_DONE;
         S_DONE:  state_d = (start_c || pending_q) ? S_PAINT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      plot       = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         S_PAINT: begin
            plot = 1'b1;
            busy = 1'b1;
         end
         S_DONE: begin
            busy       = 1'b1;
            frame_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      pending_d = pending_q;
      bx_d      = bx_q;
      by_d      = by_q;
      px_d      = px_q;
      py_d      = py_q;
      bs_d      = bs_q;
      ps_d      = ps_q;
      dig_d     = dig_q;
      if (enter_paint) begin
         x_d       = '0;
         y_d       = '0;
         pending_d = 1'b0;
         bx_d      = ballx;
         by_d      = bally;
         px_d      = platex;
         py_d      = platey;
         bs_d      = ballsize;
         ps_d      = platesize;
         dig_d     = digits;
      end else begin
         if ((state_q != S_IDLE) && start_c) pending_d = 1'b1;
         if (accept) begin
            if (x_q == XW'(SCR_W - 1)) begin
               x_d = '0;
               y_d = (y_q == YW'(SCR_H - 1)) ? '0 : y_q + YW'(1);
            end else begin
               x_d = x_q + XW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q       <= '0;
         y_q       <= '0;
         pending_q <= 1'b0;
         bx_q      <= '0;
         by_q      <= '0;
         px_q      <= '0;
         py_q      <= '0;
         bs_q      <= '0;
         ps_q      <= '0;
         dig_q     <= '0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         pending_q <= pending_d;
         bx_q      <= bx_d;
         by_q      <= by_d;
         px_q      <= px_d;
         py_q      <= py_d;
         bs_q      <= bs_d;
         ps_q      <= ps_d;
         dig_q     <= dig_d;
      end
   end

   // Object extents are compared one bit wider so that pos+size never wraps.
   assign xe = {1'b0, x_q};
   assign ye = {1'b0, y_q};
   assign xi = int'(x_q);
   assign yi = int'(y_q);

   assign ball_hit  = (xe >= {1'b0, bx_q}) && (xe <= {1'b0, bx_q} + XE'(bs_q))
                   && (ye >= {1'b0, by_q}) && (ye <= {1'b0, by_q} + YE'(bs_q));
   assign plate_hit = (xe >= {1'b0, px_q}) && (xe <= {1'b0, px_q} + XE'(ps_q))
                   && (ye >= {1'b0, py_q}) && (ye <= {1'b0, py_q} + YE'(PLATE_H - 1));

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      localparam int SX = DIG_X0 + (i % DIG_PER_ROW) * DIG_PITCH;
      localparam int SY = DIG_Y0 + (i / DIG_PER_ROW) * ROW_PITCH;
      logic [6:0] segs;
      logic [6:0] on_seg;
      assign segs      = seg7(dig_q[4*i +: 4]);
      assign on_seg[0] = (yi == SY)      && (xi >= SX) && (xi <= SX + 5);
      assign on_seg[1] = (xi == SX + 5)  && (yi >= SY) && (yi <= SY + 5);
      assign on_seg[2] = (xi == SX + 5)  && (yi >= SY + 5) && (yi <= SY + 10);
      assign on_seg[3] = (yi == SY + 10) && (xi >= SX) && (xi <= SX + 5);
      assign on_seg[4] = (xi == SX)      && (yi >= SY + 5) && (yi <= SY + 10);
      assign on_seg[5] = (xi == SX)      && (yi >= SY) && (yi <= SY + 5);
      assign on_seg[6] = (yi == SY + 5)  && (xi >= SX) && (xi <= SX + 5);
      assign dig_hit[i] = |(segs & on_seg);
   end

`ifdef FRAME_PAINTER_BORDER_EN
   assign seg_hit = (|dig_hit) || (xi == SEP_X);
`else
   assign seg_hit = |dig_hit;
`endif

   always_comb begin
      pix_c = 3'b111;
      if (seg_hit) begin
         pix_c = 3'b000;
      end else if (ball_hit) begin
         pix_c = 3'b000;
      end else if (plate_hit) begin
         pix_c = 3'b110;
      end
   end

   assign x     = x_q;
   assign y     = y_q;
   assign color = plot ? pix_c : 3'b111;

endmodule

// File: doc/frame_painter.md
FRAME_PAINTER -- requirements
Module: frame_painter

Interface
REQ-001 Parameter SCR_W, default 160, screen width in pixels.
REQ-002 Parameter SCR_H, default 120, screen height in pixels.
REQ-003 Parameter NUM_DIGITS, default 9, number of 7-segment digit fields drawn.
REQ-004 Parameter DIG_PER_ROW, default 4, digits per text row; DIG_X0 default 125, DIG_Y0 default 8, DIG_PITCH default 7, ROW_PITCH default 24: digit origin placement.
REQ-005 Parameter PLATE_H, default 4, plate height in pixels; SEP_X, default 121, separator column.
REQ-006 XW = $clog2(SCR_W), YW = $clog2(SCR_H), derived localparams, not overridable.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 ballx/platex  input  XW each  object top-left x; bally/platey  input  YW each  object top-left y.
REQ-010 ballsize/platesize  input  6 each  object extent (inclusive span = size+1 pixels).
REQ-011 digits  input  4*NUM_DIGITS  packed BCD, digit i in bits [4i+3:4i].
REQ-012 redraw  input  1  single-cycle request forcing a full repaint.
REQ-013 wr_ready  input  1  downstream pixel sink accepts a pixel this cycle.
REQ-014 x  output XW, y  output YW, color  output 3, plot  output 1  pixel write port.
REQ-015 busy  output 1  high while painting; frame_done  output 1  one-cycle pulse at frame end.

Function
REQ-016 States IDLE, PAINT, DONE; IDLE->PAINT on start condition, PAINT->DONE after last pixel accepted, DONE->PAINT if pending else IDLE, DONE lasts one cycle.
REQ-017 Start condition: redraw=1, or any of ballx/bally/platex/platey/ballsize/platesize/digits differs from the last-painted snapshot.
REQ-018 On PAINT entry all object inputs shall be captured into a snapshot; the frame shall be painted solely from the snapshot (no tearing).
REQ-019 A start condition arising while in PAINT or DONE shall set pending; pending clears on PAINT entry.
REQ-020 Raster order x=0..SCR_W-1 inner, y=0..SCR_H-1 outer; counter advances only when plot=1 and wr_ready=1.
REQ-021 plot=1 throughout PAINT; x/y/color shall hold stable while wr_ready=0.
REQ-022 Colour priority: digit segment 000 > ball 000 > plate 110 > background 111.
REQ-023 Ball hit: bx<=x<=bx+ballsize and by<=y<=by+ballsize, compared at XW+1/YW+1 bits (no wrap).
REQ-024 Plate hit: px<=x<=px+platesize and py<=y<=py+PLATE_H-1, same width rule.
REQ-025 Digit i origin: sx=DIG_X0+(i%DIG_PER_ROW)*DIG_PITCH, sy=DIG_Y0+(i/DIG_PER_ROW)*ROW_PITCH; segments 6 wide, 11 tall: top y=sy, mid y=sy+5, bottom y=sy+10, left x=sx, right x=sx+5.
REQ-026 BCD 0-9 shall render standard 7-segment glyphs; codes 10-15 render blank.
REQ-027 busy=1 in PAINT and DONE; frame_done=1 only in DONE.
REQ-028 Pixel latency: position presented in cycle n has its colour valid in cycle n (combinational on registered counters and snapshot).

Reset
REQ-029 reset=0 shall asynchronously force IDLE, x=0, y=0, color=3'b111, plot=0, busy=0, frame_done=0, pending=0, snapshot cleared to 0.
REQ-030 Reset asserted mid-frame shall abandon the frame; after release the first cycle with a start condition begins a fresh frame at (0,0).

Configuration
REQ-031 Macro FRAME_PAINTER_BORDER_EN defined: column x=SEP_X painted 000 at priority equal to digit segments.
REQ-032 Macro undefined: no separator logic; column SEP_X follows normal colour priority.

Verification
REQ-033 Defaults, ball(10,20,size 3), release reset, no wr_ready stall -> exactly 19200 plot cycles, (10,20) and (13,23) colour 000, (14,20) 111, one frame_done pulse.
REQ-034 wr_ready toggled 50% random during frame -> x/y/color stable on stalled cycles; accepted-pixel sequence identical to unstalled run.
REQ-035 Change ballx 10->40 at pixel 5000 -> frame finishes with ball at 10, pending set, second frame starts right after DONE with ball at 40.
REQ-036 digits digit0=8, digit1=0xF -> (125,8),(130,13),(125,18) all 000; digit1 region (132..137,8..18) all 111 unless ball/plate overlaps.
REQ-037 reset pulsed low at pixel (80,60) -> outputs at reset values within same cycle; after release and redraw pulse, frame restarts at (0,0).
REQ-038 FRAME_PAINTER_BORDER_EN defined, SEP_X=121 -> all pixels (121,0..119) 000; undefined -> (121,0) 111.
